// File: rtl/aes_enc_round.sv
// aes_enc_round: one forward AES round stage, fully pipelined at one block per cycle.
// It applies SubBytes (5 cycles), ShiftRows (1), MixColumns (1) and AddRoundKey (1),
// so a block is output 8 cycles after it is sampled. The state is column-major, and byte 0
// is in_data[0:7].
// Optional feature macro AES_ENC_LAST_ROUND_EN: when defined, last_round=1 bypasses MixColumns.
// When undefined, last_round is ignored and MixColumns is always applied.
module aes_enc_round (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:127] in_data,
    input  logic         in_ready,
    input  logic [0:127] round_key,
    input  logic         last_round,
    output logic [0:127] out_data,
    output logic         out_ready,
    output logic         s_box_ready
);

    localparam int SB_STAGES = 5;
    localparam int KEY_DEPTH = 7;
    localparam int LAT       = 8;

    // Forward S-box, byte x at bits [8x:8x+7].
    localparam logic [0:2047] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        return SBOX_ROM[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] f_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] f_sub_bytes(input logic [0:127] s);
        logic [0:127] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = f_sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Byte (col c, row r) takes the byte from column (c + r) mod 4 of the same row.
    function automatic logic [0:127] f_shift_rows(input logic [0:127] s);
        logic [0:127] r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[8*(4*c+w) +: 8] = s[8*(4*((c+w)%4)+w) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] f_mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c      +: 8] = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c + 8  +: 8] = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
            r[32*c + 24 +: 8] = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
        end
        return r;
    endfunction

    logic [0:127]   r_sb [SB_STAGES];
    logic [0:127]   r_sr;
    logic [0:127]   r_mc;
    logic [0:127]   r_out;
    logic [0:127]   r_key [KEY_DEPTH];
    logic [LAT-1:0] r_valid;
    logic           r_rdy;

    logic [0:127]   w_sub;
    logic [0:127]   w_shift;
    logic [0:127]   w_mix;
    logic [0:127]   w_mc_d;

    // Stage 1 registers the raw input, stage 2 the ROM output, and stages 3-5 are delay.
    assign w_sub   = f_sub_bytes(r_sb[0]);
    assign w_shift = f_shift_rows(r_sb[SB_STAGES-1]);
    assign w_mix   = f_mix_columns(r_sr);

`ifdef AES_ENC_LAST_ROUND_EN
    // Mode bit aligned with r_sr; it only selects the MixColumns stage input.
    logic r_last [KEY_DEPTH-1];

    // Delay line carrying last_round alongside its block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < KEY_DEPTH - 1; i++) r_last[i] <= 1'b0;
        end else begin
            r_last[0] <= last_round;
            for (int i = 1; i < KEY_DEPTH - 1; i++) r_last[i] <= r_last[i-1];
        end
    end

    assign w_mc_d = r_last[KEY_DEPTH-2] ? r_sr : w_mix;
`else
    logic w_unused_last;
    assign w_unused_last = last_round;
    assign w_mc_d        = w_mix;
`endif

    // Data pipeline; it updates every cycle, and out_ready alone qualifies out_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SB_STAGES; i++) r_sb[i] <= '0;
            r_sr  <= '0;
            r_mc  <= '0;
            r_out <= '0;
        end else begin
            r_sb[0] <= in_data;
            r_sb[1] <= w_sub;
            for (int i = 2; i < SB_STAGES; i++) r_sb[i] <= r_sb[i-1];
            r_sr  <= w_shift;
            r_mc  <= w_mc_d;
            r_out <= r_mc ^ r_key[KEY_DEPTH-1];
        end
    end

    // Round-key delay line; r_key[last] lines up with r_mc for AddRoundKey.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < KEY_DEPTH; i++) r_key[i] <= '0;
        end else begin
            r_key[0] <= round_key;
            for (int i = 1; i < KEY_DEPTH; i++) r_key[i] <= r_key[i-1];
        end
    end

    // Valid shift register and ready flag; in_ready is dropped until ready has risen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_valid <= {r_valid[LAT-2:0], in_ready & r_rdy};
            r_rdy   <= 1'b1;
        end
    end

    assign out_data    = r_out;
    assign out_ready   = r_valid[LAT-1];
    assign s_box_ready = r_rdy;

endmodule

// File: tb/tb_aes_enc_round.sv
// Testbench for aes_enc_round: directed FIPS-197 vectors plus a GF(2^8) reference model
// that computes the S-box by field inversion. Honours AES_ENC_LAST_ROUND_EN.
module tb_aes_enc_round;

`ifdef AES_ENC_LAST_ROUND_EN
    localparam logic LAST_EN = 1'b1;
`else
    localparam logic LAST_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [0:127] in_data = '0;
    logic         in_ready = 1'b0;
    logic [0:127] round_key = '0;
    logic         last_round = 1'b0;
    logic [0:127] out_data;
    logic         out_ready;
    logic         s_box_ready;

    int checks = 0;
    int failures = 0;

    localparam logic [0:127] R1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [0:127] R1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] R1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [0:127] RF_IN  = 128'heb598b1b402ea1c3f23813421e84e7d2;
    localparam logic [0:127] RF_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] RF_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_enc_round u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .round_key  (round_key),
        .last_round (last_round),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .s_box_ready(s_box_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, followed by the affine map.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = m_gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] m_round(input logic [0:127] st, input logic [0:127] key,
                                             input logic skip_mix);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   m [16];
        logic [0:127] r;
        for (int i = 0; i < 16; i++) a[i] = m_sbox(st[8*i +: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) t[4*c+w] = a[4*((c+w)%4)+w];
        end
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                m[4*c+w] = m_gmul(8'h02, t[4*c+w]) ^ m_gmul(8'h03, t[4*c+(w+1)%4])
                         ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = (skip_mix ? t[i] : m[i]) ^ key[8*i +: 8];
        return r;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_ready = 1'b1;
        in_data = R1_IN;
        round_key = R1_KEY;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_ready: got %b want 0", out_ready);
            end
            checks++;
            if (out_data !== 128'h0) begin
                failures++;
                $display("FAIL reset_out_data: got %h want 0", out_data);
            end
            checks++;
            if (s_box_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_s_box_ready: got %b want 0", s_box_ready);
            end
        end
        // Release between edges with in_ready still high; this pulse must be dropped.
        reset = 1'b0;
        #1;
        checks++;
        if (s_box_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: got %b want 0", s_box_ready);
        end
        tick();
        in_ready = 1'b0;
        checks++;
        if (s_box_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge: got %b want 1", s_box_ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_ready !== 1'b0) begin
                failures++;
                $display("FAIL pulse_ignored cycle %0d: got %b want 0", i, out_ready);
            end
        end
    endtask

    task automatic test_fips_round1();
        in_data = R1_IN;
        round_key = R1_KEY;
        last_round = 1'b0;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            checks++;
            if (out_ready !== (j == 7)) begin
                failures++;
                $display("FAIL round1_latency edge %0d: got %b want %b", j + 1, out_ready, j == 7);
            end
            if (j == 7) begin
                checks++;
                if (out_data !== R1_OUT) begin
                    failures++;
                    $display("FAIL round1_data: got %h want %h", out_data, R1_OUT);
                end
            end
        end
    endtask

    task automatic test_final_round();
        logic [0:127] exp_d;
        exp_d = m_round(RF_IN, RF_KEY, LAST_EN);
        in_data = RF_IN;
        round_key = RF_KEY;
        last_round = 1'b1;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        last_round = 1'b0;
        for (int j = 1; j <= 7; j++) tick();
        checks++;
        if (out_ready !== 1'b1) begin
            failures++;
            $display("FAIL final_valid: got %b want 1", out_ready);
        end
`ifdef AES_ENC_LAST_ROUND_EN
        checks++;
        if (out_data !== RF_OUT) begin
            failures++;
            $display("FAIL final_bypass: got %h want %h", out_data, RF_OUT);
        end
`else
        checks++;
        if (out_data === RF_OUT) begin
            failures++;
            $display("FAIL final_no_bypass: got %h want anything but %h", out_data, RF_OUT);
        end
`endif
        checks++;
        if (out_data !== exp_d) begin
            failures++;
            $display("FAIL final_model: got %h want %h", out_data, exp_d);
        end
        tick();
    endtask

    task automatic test_streaming();
        localparam int NS = 27;
        logic [0:127] s_in  [NS];
        logic [0:127] s_key [NS];
        logic         s_last[NS];
        logic         s_vld [NS];
        logic [0:6]   pat;
        logic         exp_v;
        logic [0:127] exp_d;
        int           k;
        pat = 7'b1001101;
        for (int i = 0; i < NS; i++) begin
            s_in[i]   = rand128();
            s_key[i]  = rand128();
            s_last[i] = 1'($urandom_range(0, 1));
            s_vld[i]  = (i < 20) ? 1'b1 : pat[i-20];
        end
        for (int j = 0; j < NS + 8; j++) begin
            if (j < NS) begin
                in_data = s_in[j];
                round_key = s_key[j];
                last_round = s_last[j];
                in_ready = s_vld[j];
            end else begin
                in_ready = 1'b0;
            end
            tick();
            k = j - 7;
            exp_v = (k >= 0 && k < NS) ? s_vld[k] : 1'b0;
            checks++;
            if (out_ready !== exp_v) begin
                failures++;
                $display("FAIL stream_valid cycle %0d: got %b want %b", j, out_ready, exp_v);
            end
            if (exp_v) begin
                exp_d = m_round(s_in[k], s_key[k], s_last[k] & LAST_EN);
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL stream_data block %0d: got %h want %h", k, out_data, exp_d);
                end
            end
        end
        last_round = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int j = 0; j < 4; j++) begin
            in_data = rand128();
            round_key = rand128();
            in_ready = 1'b1;
            tick();
        end
        in_ready = 1'b0;
        for (int j = 4; j < 7; j++) tick();
        tick();
        checks++;
        if (out_ready !== 1'b1) begin
            failures++;
            $display("FAIL midflight_first_out: got %b want 1", out_ready);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (out_ready !== 1'b0) begin
            failures++;
            $display("FAIL midflight_drop: got %b want 0", out_ready);
        end
        checks++;
        if (s_box_ready !== 1'b0) begin
            failures++;
            $display("FAIL midflight_ready: got %b want 0", s_box_ready);
        end
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        in_data = R1_IN;
        round_key = R1_KEY;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            checks++;
            if (out_ready !== (j == 7)) begin
                failures++;
                $display("FAIL after_reset_valid edge %0d: got %b want %b", j, out_ready, j == 7);
            end
            if (j == 7) begin
                checks++;
                if (out_data !== R1_OUT) begin
                    failures++;
                    $display("FAIL after_reset_data: got %h want %h", out_data, R1_OUT);
                end
            end
        end
    endtask

    task automatic test_key_alignment();
        localparam int NA = 6;
        logic [0:127] exp_d;
        logic         lst;
        int           k;
        for (int j = 0; j < NA + 8; j++) begin
            if (j < NA) begin
                in_data = j[0] ? RF_IN : R1_IN;
                round_key = j[0] ? RF_KEY : R1_KEY;
                last_round = j[0];
                in_ready = 1'b1;
            end else begin
                in_ready = 1'b0;
            end
            tick();
            k = j - 7;
            checks++;
            if (out_ready !== (k >= 0 && k < NA)) begin
                failures++;
                $display("FAIL align_valid cycle %0d: got %b want %b", j, out_ready,
                         k >= 0 && k < NA);
            end
            if (k >= 0 && k < NA) begin
                lst = k[0];
                exp_d = lst ? m_round(RF_IN, RF_KEY, LAST_EN) : R1_OUT;
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL align_data block %0d: got %h want %h", k, out_data, exp_d);
                end
            end
        end
        last_round = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fips_round1();
        test_final_round();
        test_streaming();
        test_reset_midflight();
        test_key_alignment();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
